// File: rtl/dataflow_perf_monitor.sv
// Multi-channel ap_ctrl_chain performance monitor: per-channel latency, interval, stall and error statistics.
// Optional watchdog (per-channel timeout port and status bit 3) is enabled by defining DF_MONITOR_WATCHDOG_EN.
module dataflow_perf_monitor #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int TS_W         = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int TIMEOUT      = 1024,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] err
`ifdef DF_MONITOR_WATCHDOG_EN
    ,
    output logic [NUM_CH-1:0] timeout
`endif
);

    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int OCC_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_INFLIGHT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);

    if (NUM_CH < 1 || NUM_CH > 16 || MAX_INFLIGHT < 1 ||
        (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("dataflow_perf_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} ch_state_t;

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  fifo_mem      [NUM_CH][MAX_INFLIGHT];
    logic [PTR_W-1:0] rd_ptr        [NUM_CH];
    logic [PTR_W-1:0] wr_ptr        [NUM_CH];
    logic [OCC_W-1:0] occ           [NUM_CH];
    logic [OCC_W-1:0] occ_next      [NUM_CH];
    ch_state_t        state         [NUM_CH];
    logic [CNT_W-1:0] txn_count     [NUM_CH];
    logic [CNT_W-1:0] last_latency  [NUM_CH];
    logic [CNT_W-1:0] min_latency   [NUM_CH];
    logic [CNT_W-1:0] max_latency   [NUM_CH];
    logic [CNT_W-1:0] last_interval [NUM_CH];
    logic [CNT_W-1:0] interval_cnt  [NUM_CH];
    logic [CNT_W-1:0] stall_cycles  [NUM_CH];
    logic [CNT_W-1:0] latency       [NUM_CH];
    logic [NUM_CH-1:0] seen_start, ovf_flag, unf_flag, tmo;
    logic [NUM_CH-1:0] start_ev, done_ev, stall_ev, do_push, do_pop, ovf, unf, lat_valid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A done with a simultaneous start on an empty FIFO is a zero-latency pass-through, not an underflow.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            start_ev[c]  = ap_start[c] & ap_ready[c];
            done_ev[c]   = ap_done[c] & ap_continue[c];
            stall_ev[c]  = ap_done[c] & ~ap_continue[c];
            do_pop[c]    = done_ev[c] & (occ[c] != '0);
            do_push[c]   = start_ev[c] & (done_ev[c] ? (occ[c] != '0) : (occ[c] != OCC_FULL));
            ovf[c]       = start_ev[c] & ~done_ev[c] & (occ[c] == OCC_FULL);
            unf[c]       = done_ev[c] & ~start_ev[c] & (occ[c] == '0);
            lat_valid[c] = done_ev[c] & ~unf[c];
            latency[c]   = (occ[c] == '0) ? '0 : CNT_W'(ts - fifo_mem[c][rd_ptr[c]]);
            occ_next[c]  = occ[c] + OCC_W'(do_push[c]) - OCC_W'(do_pop[c]);
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!reset && !clear && !finish && do_push[c])
                fifo_mem[c][wr_ptr[c]] <= ts;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts   <= '0;
            busy <= '0;
            err  <= '0;
            seen_start <= '0;
            ovf_flag   <= '0;
            unf_flag   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= ST_IDLE;
                occ[c] <= '0;
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                txn_count[c] <= '0;
                last_latency[c] <= '0;
                min_latency[c] <= '1;
                max_latency[c] <= '0;
                last_interval[c] <= '0;
                interval_cnt[c] <= '0;
                stall_cycles[c] <= '0;
            end
        end else begin
            ts <= ts + TS_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear) begin
                    busy[c] <= 1'b0;
                    err[c]  <= 1'b0;
                    seen_start[c] <= 1'b0;
                    ovf_flag[c]   <= 1'b0;
                    unf_flag[c]   <= 1'b0;
                    state[c] <= ST_IDLE;
                    occ[c] <= '0;
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                    txn_count[c] <= '0;
                    last_latency[c] <= '0;
                    min_latency[c] <= '1;
                    max_latency[c] <= '0;
                    last_interval[c] <= '0;
                    interval_cnt[c] <= '0;
                    stall_cycles[c] <= '0;
                end else if (!finish) begin
                    occ[c] <= occ_next[c];
                    if (do_push[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                    if (do_pop[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                    if (done_ev[c]) txn_count[c] <= sat_inc(txn_count[c]);
                    if (stall_ev[c]) stall_cycles[c] <= sat_inc(stall_cycles[c]);
                    // Latency history is frozen once the channel has seen a protocol error.
                    if (lat_valid[c] && state[c] != ST_ERR) begin
                        last_latency[c] <= latency[c];
                        if (latency[c] < min_latency[c]) min_latency[c] <= latency[c];
                        if (latency[c] > max_latency[c]) max_latency[c] <= latency[c];
                    end
                    if (start_ev[c]) begin
                        if (seen_start[c]) last_interval[c] <= interval_cnt[c];
                        interval_cnt[c] <= CNT_W'(1);
                        seen_start[c]   <= 1'b1;
                    end else if (seen_start[c]) begin
                        interval_cnt[c] <= sat_inc(interval_cnt[c]);
                    end
                    if (ovf[c]) ovf_flag[c] <= 1'b1;
                    if (unf[c]) unf_flag[c] <= 1'b1;
                    if (ovf[c] || unf[c] || state[c] == ST_ERR)
                        state[c] <= ST_ERR;
                    else
                        state[c] <= (occ_next[c] != '0) ? ST_BUSY : ST_IDLE;
                    busy[c] <= (occ_next[c] != '0);
                    err[c]  <= (state[c] == ST_ERR) | ovf[c] | unf[c];
                end
            end
        end
    end

`ifdef DF_MONITOR_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] idle_cnt [NUM_CH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo <= '0;
            for (int c = 0; c < NUM_CH; c++) idle_cnt[c] <= '0;
        end else if (clear) begin
            tmo <= '0;
            for (int c = 0; c < NUM_CH; c++) idle_cnt[c] <= '0;
        end else if (!finish) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (done_ev[c]) begin
                    idle_cnt[c] <= '0;
                end else if (occ[c] != '0 && idle_cnt[c] != WD_LIMIT) begin
                    idle_cnt[c] <= idle_cnt[c] + WD_W'(1);
                    if (idle_cnt[c] == WD_LIMIT - WD_W'(1)) tmo[c] <= 1'b1;
                end
            end
        end
    end

    assign timeout = tmo;
`else
    assign tmo = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (int'(rd_ch) >= NUM_CH) begin
            rd_data <= '0;
        end else begin
            case (rd_sel)
                3'd0:    rd_data <= txn_count[rd_ch];
                3'd1:    rd_data <= last_latency[rd_ch];
                3'd2:    rd_data <= min_latency[rd_ch];
                3'd3:    rd_data <= max_latency[rd_ch];
                3'd4:    rd_data <= last_interval[rd_ch];
                3'd5:    rd_data <= stall_cycles[rd_ch];
                3'd6:    rd_data <= CNT_W'(occ[rd_ch]);
                default: rd_data <= CNT_W'({tmo[rd_ch], unf_flag[rd_ch], ovf_flag[rd_ch], busy[rd_ch]});
            endcase
        end
    end

endmodule
